gpio_ctrl: RTL

//   Register-mapped controller for the N_GPIO-pin bidirectional GPIO port. Drives per-pin
//   tri-state enables and output values into the pad buffers, synchronises pad inputs and

---
 rtl/gpio_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped GPIO controller with per-pin input synchronisers,
// edge detection into W1C pending bits and a registered level interrupt.

module gpio_pin #(
    parameter int SYNC_FF = 2
) (
    input  logic clk,
    input  logic rstn_i,
    input  logic pad_i,
    input  logic rise_en_i,
    input  logic fall_en_i,
    input  logic w1c_i,
    output logic s_o,
    output logic pend_o
);
    logic [SYNC_FF-1:0] sync_q, sync_d;
    logic               h_q;
    logic               pend_q, pend_d;
    logic               ev;

    assign s_o    = sync_q[SYNC_FF-1];
    assign pend_o = pend_q;
    assign sync_d = {sync_q[SYNC_FF-2:0], pad_i};
    assign ev     = (s_o & ~h_q & rise_en_i) | (~s_o & h_q & fall_en_i);
    // An edge event landing on the same edge as a clear keeps the bit set.
    assign pend_d = ev | (pend_q & ~w1c_i);

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            sync_q <= '0;
            h_q    <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            h_q    <= s_o;
            pend_q <= pend_d;
        end
    end
endmodule

module gpio_ctrl #(
    parameter int N_GPIO  = 8,
    parameter int SYNC_FF = 2
) (
    input  logic              clk,
    input  logic              rstn_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [4:0]        addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic [N_GPIO-1:0] gpio_dir_o,
    output logic [N_GPIO-1:0] gpio_val_o,
    input  logic [N_GPIO-1:0] gpio_val_i,
    output logic              irq_o
);
    typedef enum logic {IDLE, RESP} state_t;
    typedef struct packed {
        logic       we;
        logic [2:0] idx;
    } req_t;

    localparam logic [2:0] A_DIR  = 3'd0;
    localparam logic [2:0] A_OUT  = 3'd1;
    localparam logic [2:0] A_IN   = 3'd2;
    localparam logic [2:0] A_IEN  = 3'd3;
    localparam logic [2:0] A_PEND = 3'd4;
    localparam logic [2:0] A_RISE = 3'd5;
    localparam logic [2:0] A_FALL = 3'd6;
    localparam logic [2:0] A_UNM  = 3'd7;

    state_t            state_q, state_d;
    req_t              req_q, req_d;
    logic [N_GPIO-1:0] dir_q, dir_d, out_q, out_d, ien_q, ien_d;
    logic [N_GPIO-1:0] rise_q, rise_d, fall_q, fall_d;
    logic [N_GPIO-1:0] sync_s, pend, w1c, wd;
    logic              irq_q, irq_d;
    logic              acc, wr;
    logic              unused_bits;

    assign acc         = (state_q == IDLE) & req_i;
    assign wr          = acc & we_i;
    assign wd          = wdata_i[N_GPIO-1:0];
    assign w1c         = (wr && addr_i[4:2] == A_PEND) ? wd : '0;
    assign irq_d       = |(pend & ien_q);
    assign unused_bits = ^{addr_i[1:0], wdata_i};

    for (genvar i = 0; i < N_GPIO; i++) begin : g_pin
        gpio_pin #(.SYNC_FF(SYNC_FF)) u_pin (
            .clk       (clk),
            .rstn_i    (rstn_i),
            .pad_i     (gpio_val_i[i]),
            .rise_en_i (rise_q[i]),
            .fall_en_i (fall_q[i]),
            .w1c_i     (w1c[i]),
            .s_o       (sync_s[i]),
            .pend_o    (pend[i])
        );
    end

    // Writes commit on the accepting edge so pads update in the RESP cycle.
    always_comb begin
        req_d  = req_q;
        dir_d  = dir_q;
        out_d  = out_q;
        ien_d  = ien_q;
        rise_d = rise_q;
        fall_d = fall_q;
        if (acc) begin
            req_d = '{we: we_i, idx: addr_i[4:2]};
            if (we_i) begin
                case (addr_i[4:2])
                    A_DIR:   dir_d  = wd;
                    A_OUT:   out_d  = wd;
                    A_IEN:   ien_d  = wd;
                    A_RISE:  rise_d = wd;
                    A_FALL:  fall_d = wd;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        err_o   = 1'b0;
        rdata_o = '0;
        case (state_q)
            IDLE: if (req_i) state_d = RESP;
            RESP: begin
                state_d = IDLE;
                ready_o = 1'b1;
                err_o   = (req_q.idx == A_UNM);
                if (!req_q.we) begin
                    case (req_q.idx)
                        A_DIR:   rdata_o = 32'(dir_q);
                        A_OUT:   rdata_o = 32'(out_q);
                        A_IN:    rdata_o = 32'(sync_s);
                        A_IEN:   rdata_o = 32'(ien_q);
                        A_PEND:  rdata_o = 32'(pend);
                        A_RISE:  rdata_o = 32'(rise_q);
                        A_FALL:  rdata_o = 32'(fall_q);
                        default: rdata_o = '0;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            dir_q   <= '0;
            out_q   <= '0;
            ien_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            dir_q   <= dir_d;
            out_q   <= out_d;
            ien_q   <= ien_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            irq_q   <= irq_d;
        end
    end

    assign gpio_dir_o = ~dir_q;
    assign gpio_val_o = out_q;
    assign irq_o      = irq_q;
endmodule
